// File: rtl/data_mem_hs.sv
// RV32 byte-addressed data memory: byte/half/word access, load extension, valid/ready handshake.
// Optional DMEM_MISALIGN_ERR_EN turns misaligned half/word accesses into faults. Array is not reset.
module data_mem_hs #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        o_dbg_state
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready; a response
    // transfers with rsp_valid && rsp_ready. req_ready = !rsp_valid || rsp_ready.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic [31:0]   w_offset;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_misalign;
    logic          w_err;
    logic          w_accept;
    logic          w_write;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_lanes;
    logic [31:0]   w_word;
    logic [31:0]   w_shifted;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    assign w_offset = req_addr - BASE_ADDR;
    assign w_idx    = w_offset[AW+1:2];
    assign w_lane   = w_offset[1:0];

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_misalign = ((req_size == 2'b01) && w_lane[0]) ||
                        ((req_size == 2'b10) && (w_lane != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err     = (w_offset >= SPAN) || (req_size == 2'b11) || w_misalign;
    assign rsp_valid = (r_state == S_RESP);
    assign req_ready = !rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;
    assign w_write   = w_accept && req_we && !w_err;

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        w_be          = 4'b0000;
        w_wdata_lanes = req_wdata;
        case (req_size)
            2'b00: begin
                w_be          = 4'b0001 << w_lane;
                w_wdata_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be          = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata_lanes = {2{req_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
            end
        end
    end

    assign w_word    = r_mem[w_idx];
    assign w_shifted = w_word >> {w_lane, 3'b000};
    assign w_half    = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = 32'h0;
        case (req_size)
            2'b00: w_load = req_unsigned ? {24'h0, w_shifted[7:0]}
                                         : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01: w_load = req_unsigned ? {16'h0, w_half}
                                         : {{16{w_half[15]}}, w_half};
            2'b10:   w_load = w_word;
            default: w_load = 32'h0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_RESP;
            S_RESP:  if (rsp_ready && !w_accept) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || req_we) ? 32'h0 : w_load;
            end
        end
    end

    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: directed spec scenarios then randomized traffic, all checked against
// a byte-array reference model and an in-order expected-response queue.
module tb_data_mem_hs;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          SPAN  = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dbg_state;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          rand_ready = 1'b0;
    logic [32:0] exp_q[$];
    logic [7:0]  model_mem [SPAN];

    data_mem_hs #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: a flat byte array; an access covers 2**size bytes starting at the offset
    // rounded down to that size. Result is {err, rdata}.
    function automatic logic [32:0] model(input logic we, input logic [1:0] size, input logic uns,
                                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] off;
        logic [31:0] v;
        logic        err;
        int          n;
        int          start;
        off = addr - BASE;
        err = (off >= 32'(SPAN)) || (size == 2'b11);
`ifdef DMEM_MISALIGN_ERR_EN
        if (size == 2'b01 && addr[0]) err = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) err = 1'b1;
`endif
        if (err) return {1'b1, 32'h0};
        n     = 1 << size;
        start = int'(off) - (int'(off) % n);
        if (we) begin
            for (int i = 0; i < n; i++) model_mem[start + i] = wdata[8*i +: 8];
            return {1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[start + i];
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return {1'b0, v};
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        bit done;
        done         = 1'b0;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (req_ready) begin
                exp_q.push_back(model(we, size, uns, addr, wdata));
                @(posedge clk); #1;
                done = 1'b1;
                chk("latency_rsp_valid", {32'h0, rsp_valid}, 33'd1);
            end else begin
                @(posedge clk); #1;
            end
        end
        req_valid = 1'b0;
        if (!done) chk("accept_timeout", 33'd1, 33'd0);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("drain_queue_empty", 33'(exp_q.size()), 33'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 33'd1, 33'd0);
            else chk("rsp_err_rdata", {rsp_err, rsp_rdata}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] held;
        int          c0;
        for (int i = 0; i < SPAN; i++) model_mem[i] = 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_rsp_valid", {32'h0, rsp_valid}, 33'd0);
        chk("reset_rsp_rdata", {1'b0, rsp_rdata}, 33'd0);
        chk("reset_rsp_err",   {32'h0, rsp_err}, 33'd0);
        chk("reset_req_ready", {32'h0, req_ready}, 33'd1);
        chk("reset_dbg_state", {32'h0, dbg_state}, 33'd0);
        @(posedge clk); #1;

        // Known contents for the low 128 bytes used below.
        for (int w = 0; w < 32; w++) send(1'b1, 2'b10, 1'b0, BASE + 32'(4 * w), 32'h0);
        drain();

        send(1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'h8765_4321);
        send(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0);
        send(1'b1, 2'b00, 1'b0, BASE + 32'h13, 32'h0000_00AB);
        send(1'b0, 2'b00, 1'b0, BASE + 32'h13, 32'h0);
        send(1'b0, 2'b00, 1'b1, BASE + 32'h13, 32'h0);
        send(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0);
        send(1'b1, 2'b01, 1'b0, BASE + 32'h22, 32'h0000_8001);
        send(1'b0, 2'b01, 1'b0, BASE + 32'h22, 32'h0);
        send(1'b0, 2'b01, 1'b1, BASE + 32'h22, 32'h0);
        send(1'b0, 2'b10, 1'b0, BASE + 32'h20, 32'h0);
        drain();

        // Stall the response for 3 cycles with a second load waiting behind it.
        rsp_ready = 1'b0;
        send(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0);
        held = exp_q[0];
        req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = BASE + 32'h13; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("hold_req_ready", {32'h0, req_ready}, 33'd0);
            chk("hold_rsp_valid", {32'h0, rsp_valid}, 33'd1);
            chk("hold_rsp_fields", {rsp_err, rsp_rdata}, held);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("release_req_ready", {32'h0, req_ready}, 33'd1);
        exp_q.push_back(model(1'b0, 2'b00, 1'b0, BASE + 32'h13, 32'h0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("release_reload_valid", {32'h0, rsp_valid}, 33'd1);
        drain();

        // Back-to-back loads: one accept per cycle.
        c0 = cyc;
        for (int i = 0; i < 6; i++) send(1'b0, 2'b10, 1'b0, BASE + 32'(4 * i + 16), 32'h0);
        chk("b2b_cycles", 33'(cyc - c0), 33'd6);
        drain();

        // Faults: range, size, and misalignment.
        send(1'b0, 2'b10, 1'b0, BASE + 32'(SPAN), 32'h0);
        send(1'b0, 2'b10, 1'b0, BASE - 32'h4, 32'h0);
        send(1'b0, 2'b11, 1'b0, BASE + 32'h10, 32'h0);
        send(1'b1, 2'b10, 1'b0, BASE + 32'(SPAN), 32'hDEAD_BEEF);
        send(1'b1, 2'b00, 1'b0, BASE + 32'(SPAN) + 32'h10, 32'h0000_0055);
        send(1'b1, 2'b11, 1'b0, BASE + 32'h10, 32'hFFFF_FFFF);
        send(1'b0, 2'b10, 1'b0, BASE, 32'h0);
        send(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0);
        send(1'b1, 2'b10, 1'b0, BASE + 32'h0, 32'h1122_3344);
        send(1'b0, 2'b10, 1'b0, BASE + 32'h2, 32'h0);
        send(1'b1, 2'b01, 1'b0, BASE + 32'h31, 32'h0000_A5C3);
        send(1'b0, 2'b10, 1'b0, BASE + 32'h30, 32'h0);
        send(1'b0, 2'b01, 1'b0, BASE + 32'h3, 32'h0);
        drain();

        // Reset while a response is pending.
        rsp_ready = 1'b0;
        send(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", {32'h0, rsp_valid}, 33'd0);
        chk("midreset_rsp_rdata", {1'b0, rsp_rdata}, 33'd0);
        chk("midreset_req_ready", {32'h0, req_ready}, 33'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        send(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0);
        send(1'b0, 2'b10, 1'b0, BASE + 32'h0, 32'h0);
        drain();

        // Randomized traffic with random response back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [1:0]  s;
            s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = BASE + 32'(SPAN) + 32'($urandom_range(0, 15));
            else a = BASE + 32'($urandom_range(0, 127));
            send(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
        end
        rand_ready = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
